lsu_mc: RTL and testbench

LSU_MC -- requirements
Module: lsu_mc

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_mc.sv | 144 ++++++++++++++
 tb/tb_lsu_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RISC-V funct3
// load/store encodings and the access-size/legality decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // log2 of the access size in bytes; unsigned loads share the low bits
  function automatic logic [1:0] size_lg2(input logic [2:0] func3);
    return func3[1:0];
  endfunction

  function automatic logic func3_legal(input logic write, input logic [2:0] func3,
                                       input logic is64);
    logic ok;
    if (write) ok = !func3[2] && ((func3 != F3_D) || is64);
    else       ok = (func3 != 3'b111) && (((func3 != F3_D) && (func3 != F3_WU)) || is64);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte-lane extraction with sign/zero
// extension, store data replication and byte-strobe generation.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int LG   = $clog2(XLEN / 8)
) (
  input  logic            write_i,
  input  logic [2:0]      func3_i,
  input  logic [LG-1:0]   off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [NB-1:0]   wstrb_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      mask8;
  logic            sgn;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    sgn     = !func3_i[2];
    rdata_o = shifted;
    wdata_o = wdata_i;
    mask8   = 8'hFF;
    // Fill with the sign bit first, then overlay the payload bytes
    case (func3_i)
      F3_B, F3_BU: begin
        rdata_o       = {XLEN{sgn & shifted[7]}};
        rdata_o[7:0]  = shifted[7:0];
        wdata_o       = {NB{wdata_i[7:0]}};
        mask8         = 8'h01;
      end
      F3_H, F3_HU: begin
        rdata_o       = {XLEN{sgn & shifted[15]}};
        rdata_o[15:0] = shifted[15:0];
        wdata_o       = {(NB/2){wdata_i[15:0]}};
        mask8         = 8'h03;
      end
      F3_W, F3_WU: begin
        rdata_o       = {XLEN{sgn & shifted[31]}};
        rdata_o[31:0] = shifted[31:0];
        wdata_o       = {(NB/4){wdata_i[31:0]}};
        mask8         = 8'h0F;
      end
      default: ;
    endcase
    wstrb_o = write_i ? (mask8[NB-1:0] << off_i) : '0;
  end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: accepts one request, performs a single
// aligned memory access with timeout, and holds the response until taken.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_func3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int NB    = XLEN / 8;
  localparam int LG    = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   loadData;
  logic [XLEN-1:0]   storeData;
  logic [NB-1:0]     storeStrb;
  logic              legal;
  logic              misaligned;

  assign legal      = func3_legal(req_write, req_func3, XLEN == 64);
  assign misaligned = |(req_addr[2:0] & ((3'b001 << size_lg2(req_func3)) - 3'b001));

  lsu_align #(.XLEN(XLEN)) u_align (
    .write_i (write_q),
    .func3_i (func3_q),
    .off_i   (addr_q[LG-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem_rdata),
    .wdata_o (storeData),
    .wstrb_o (storeStrb),
    .rdata_o (loadData)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (!legal || misaligned) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : loadData;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_valid = (state_q == ST_MEM);
  assign mem_write = write_q;
  assign mem_addr  = {addr_q[ADDR_W-1:LG], {LG{1'b0}}};
  assign mem_wdata = storeData;
  assign mem_wstrb = storeStrb;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsu_mc.sv
// Scoreboard bench for lsu_mc (XLEN=32, TIMEOUT=4): directed loads/stores,
// illegal/misaligned requests, timeout, response back-pressure and mid-access reset.
module tb_lsu_mc;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [2:0]        req_func3 = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } memExp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rspExp_t;

  memExp_t memQ[$];
  rspExp_t rspQ[$];
  memExp_t memPop;
  rspExp_t rspPop;

  lsu_mc #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever a memory or response handshake occurs
  always @(negedge clk) begin
    if (clr && mem_valid && mem_ready) begin
      if (memQ.size() == 0) begin
        checkOutput("memUnexpected", 64'd1, 64'd0);
      end else begin
        memPop = memQ.pop_front();
        checkOutput("memWrite", mem_write, memPop.write);
        checkOutput("memAddr", mem_addr, memPop.addr);
        checkOutput("memWstrb", mem_wstrb, memPop.wstrb);
        if (memPop.write) checkOutput("memWdata", mem_wdata, memPop.wdata);
      end
    end
    if (clr && rsp_valid && rsp_ready) begin
      if (rspQ.size() == 0) begin
        checkOutput("rspUnexpected", 64'd1, 64'd0);
      end else begin
        rspPop = rspQ.pop_front();
        checkOutput("rspRdata", rsp_rdata, rspPop.rdata);
        checkOutput("rspErr", rsp_err, rspPop.err);
      end
    end
  end

  task automatic applyStimulus(
    input logic w, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] memRdata,
    input int readyLat, input int rspStall, input logic expMem,
    input logic [31:0] expAddr, input logic [3:0] expWstrb, input logic [31:0] expWdata,
    input logic [31:0] expRdata, input logic expErr);
    int waitCnt;
    int edges;
    int memCycles;
    int expCycles;
    bit timedOut;
    memExp_t me;
    rspExp_t re;
    timedOut = expMem && (readyLat >= TIMEOUT);
    if (expMem && !timedOut) begin
      me.write = w;
      me.addr  = expAddr;
      me.wstrb = expWstrb;
      me.wdata = expWdata;
      memQ.push_back(me);
    end
    re.rdata = expRdata;
    re.err   = expErr;
    rspQ.push_back(re);

    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("reqReadyIdle", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    mem_rdata = memRdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_func3 = ~f3;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    checkOutput("busyAfterAccept", busy, 1);

    edges = 0;
    memCycles = 0;
    while (!rsp_valid && edges < 50) begin
      if (mem_valid) begin
        checkOutput("memAddrHold", mem_addr, expAddr);
        checkOutput("memWstrbHold", mem_wstrb, expWstrb);
        mem_ready = (memCycles == readyLat);
        memCycles++;
      end else begin
        mem_ready = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    mem_ready = 1'b0;
    expCycles = !expMem ? 0 : (timedOut ? TIMEOUT : readyLat + 1);
    checkOutput("rspLatency", edges, expCycles);
    checkOutput("memValidCycles", memCycles, expCycles);
    checkOutput("memValidDropped", mem_valid, 0);

    for (int s = 0; s < rspStall; s++) begin
      checkOutput("rspHoldValid", rsp_valid, 1);
      checkOutput("rspHoldRdata", rsp_rdata, expRdata);
      checkOutput("rspHoldErr", rsp_err, expErr);
      checkOutput("reqReadyInResp", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rspDone", rsp_valid, 0);
    checkOutput("reqReadyAfterRsp", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #12;
    checkOutput("rstMemValid", mem_valid, 0);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstRspErr", rsp_err, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstRspRdata", rsp_rdata, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("reqReadyAfterRst", req_ready, 1);

    //             w     f3      addr          wdata         memRdata      lat st mem expAddr       strb     expWdata      expRdata      err
    applyStimulus(1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 0, 0, 1, 32'h0000_0008, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h0000_0003, 32'h0,        32'h80FF_FF7F, 1, 0, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h0000_0003, 32'h0,        32'h80FF_FF7F, 0, 0, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_0080, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h0000_0006, 32'h0000_1234, 32'hFFFF_FFFF, 2, 1, 1, 32'h0000_0004, 4'b1100, 32'h1234_1234, 32'h0,        1'b0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    applyStimulus(1'b0, 3'b010, 32'h0000_000C, 32'h0,        32'h5555_AAAA, 99, 3, 1, 32'h0000_000C, 4'b0000, 32'h0,       32'h0,        1'b1);
    applyStimulus(1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'hABCD_1234, 0, 0, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_ABCD, 1'b0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hABCD_1234, 3, 0, 1, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_ABCD, 1'b0);
    applyStimulus(1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
    applyStimulus(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 0, 1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    applyStimulus(1'b0, 3'b111, 32'h0000_0000, 32'h0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    applyStimulus(1'b0, 3'b110, 32'h0000_0004, 32'h0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    applyStimulus(1'b1, 3'b100, 32'h0000_0000, 32'h1,        32'hFFFF_FFFF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    applyStimulus(1'b1, 3'b010, 32'h0000_0006, 32'h1,        32'hFFFF_FFFF, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);

    // Reset in the middle of a memory access: the access is dropped silently
    while (!req_ready) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_func3 = 3'b010;
    req_addr  = 32'h0000_0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("midMemValid", mem_valid, 1);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    checkOutput("midRstMemValid", mem_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstRspValid", rsp_valid, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstReqReady", req_ready, 1);
    repeat (3) begin
      checkOutput("midRstNoRsp", rsp_valid, 0);
      @(posedge clk); #1;
    end

    applyStimulus(1'b0, 3'b010, 32'h0000_0024, 32'h0, 32'h1357_9BDF, 0, 0, 1, 32'h0000_0024, 4'b0000, 32'h0, 32'h1357_9BDF, 1'b0);

    repeat (2) @(posedge clk);
    checkOutput("memQueueEmpty", memQ.size(), 0);
    checkOutput("rspQueueEmpty", rspQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
